// File: rtl/mult_pkg.sv
// Shared definitions for the multiplier family.
// Provides the controller state encoding, the default operand width and a
// helper that sizes the step counter for a given operand width.
package mult_pkg;

    localparam int unsigned MULT_N_DEFAULT = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    // ceil(log2(n)) with a floor of one bit, so that a counter holding
    // values 0..n-1 always has a legal width.
    function automatic int unsigned cnt_width(input int unsigned n);
        int unsigned w;
        w = 1;
        while ((32'd1 << w) < n) begin
            w = w + 1;
        end
        return w;
    endfunction

endpackage

// File: rtl/nbit_ripple_adder.sv
// N-bit ripple-carry adder assembled from half/full adder cells.
// Ports:
//   x, y  : N-bit addends
//   s     : N-bit sum
//   cout  : carry out of the most significant bit
// Bit 0 has no carry in, so it uses a half adder; every higher bit is a
// full adder fed by the carry of the bit below.

// Single-bit half adder cell.
module half_adder (
    input  logic x,
    input  logic y,
    output logic s,
    output logic c
);
    assign s = x ^ y;
    assign c = x & y;
endmodule

// Single-bit full adder cell.
module full_adder (
    input  logic x,
    input  logic y,
    input  logic cin,
    output logic s,
    output logic cout
);
    assign s    = x ^ y ^ cin;
    assign cout = (x & y) | (cin & (x ^ y));
endmodule

module nbit_ripple_adder #(
    parameter int unsigned N = 8
) (
    input  logic [N-1:0] x,
    input  logic [N-1:0] y,
    output logic [N-1:0] s,
    output logic         cout
);

    // carry_s[i] is the carry out of bit i
    logic [N-1:0] carry_s;

    half_adder u_ha0 (
        .x (x[0]),
        .y (y[0]),
        .s (s[0]),
        .c (carry_s[0])
    );

    genvar i;
    generate
        for (i = 1; i < N; i = i + 1) begin : g_fa
            full_adder u_fa (
                .x    (x[i]),
                .y    (y[i]),
                .cin  (carry_s[i-1]),
                .s    (s[i]),
                .cout (carry_s[i])
            );
        end
    endgenerate

    assign cout = carry_s[N-1];

endmodule

// File: rtl/seq_mult_ctrl.sv
// Sequential shift-add unsigned multiplier controller.
// One N-bit ripple adder is reused over N clock cycles to form a 2N-bit
// product.
// Ports:
//   clk    : rising-edge clock
//   rst    : asynchronous active-high reset
//   start  : request, sampled only while idle
//   a, b   : multiplicand / multiplier, captured when start is accepted
//   busy   : high while an operation is running or completing
//   done   : one-cycle pulse, p is valid from this cycle on
//   p      : product register, held until the next completion
module seq_mult_ctrl
    import mult_pkg::*;
#(
    parameter int unsigned N = MULT_N_DEFAULT
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           start,
    input  logic [N-1:0]   a,
    input  logic [N-1:0]   b,
    output logic           busy,
    output logic           done,
    output logic [2*N-1:0] p
);

    localparam int unsigned CW = cnt_width(N);

    state_t          state_q, state_d;
    logic [N-1:0]    areg_q, areg_d;
    logic [N-1:0]    hi_q, hi_d;
    logic [N-1:0]    lo_q, lo_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [2*N-1:0]  p_q, p_d;
    logic            busy_q, busy_d;
    logic            done_q, done_d;

    logic [N-1:0]    addend_s;
    logic [N-1:0]    sum_s;
    logic            cout_s;
    logic [2*N-1:0]  shifted_s;

    // The multiplier LSB decides whether the multiplicand is added this step.
    assign addend_s = lo_q[0] ? areg_q : {N{1'b0}};

    nbit_ripple_adder #(
        .N (N)
    ) u_adder (
        .x    (hi_q),
        .y    (addend_s),
        .s    (sum_s),
        .cout (cout_s)
    );

    // Right shift of {carry, sum, lo}: the carry lands in the hi MSB and the
    // consumed multiplier bit drops off the bottom.
    assign shifted_s = {cout_s, sum_s, lo_q[N-1:1]};

    // Next-state and datapath update logic.
    always_comb begin
        state_d = state_q;
        areg_d  = areg_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
        cnt_d   = cnt_q;
        p_d     = p_q;

        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = RUN;
                    areg_d  = a;
                    lo_d    = b;
                    hi_d    = {N{1'b0}};
                    cnt_d   = CW'(N - 1);
                end else begin
                    state_d = IDLE;
                end
            end
            RUN: begin
                {hi_d, lo_d} = shifted_s;
                if (cnt_q == {CW{1'b0}}) begin
                    p_d     = shifted_s;
                    state_d = DONE;
                end else begin
                    cnt_d   = cnt_q - CW'(1);
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // Status flags are registered from the next state so they line up
        // exactly with the state they describe.
        busy_d = (state_d != IDLE);
        done_d = (state_d == DONE);
    end

    // State, datapath and output registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            areg_q  <= {N{1'b0}};
            hi_q    <= {N{1'b0}};
            lo_q    <= {N{1'b0}};
            cnt_q   <= {CW{1'b0}};
            p_q     <= {(2*N){1'b0}};
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            areg_q  <= areg_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
            cnt_q   <= cnt_d;
            p_q     <= p_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign busy = busy_q;
    assign done = done_q;
    assign p    = p_q;

endmodule

// File: tb/tb_seq_mult_ctrl.sv
// Self-checking bench for seq_mult_ctrl (N = 8).
module tb_seq_mult_ctrl;

    localparam int N = 8;

    logic           clk = 1'b0;
    logic           rst;
    logic           start;
    logic [N-1:0]   a;
    logic [N-1:0]   b;
    logic           busy;
    logic           done;
    logic [2*N-1:0] p;

    int vectors    = 0;
    int miscompares = 0;

    seq_mult_ctrl #(.N(N)) dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .a     (a),
        .b     (b),
        .busy  (busy),
        .done  (done),
        .p     (p)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Behavioural model: an accepted request makes the unit busy for N+1
    // cycles, with the result a*b appearing and done pulsing in the last one.
    // m_k counts clock edges since acceptance, -1 when idle.
    int             m_k;
    logic [2*N-1:0] m_prod;
    logic [2*N-1:0] p_exp;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_k    <= -1;
            m_prod <= '0;
            p_exp  <= '0;
        end else if (m_k < 0) begin
            if (start) begin
                m_k    <= 0;
                m_prod <= (2*N)'(a) * (2*N)'(b);
            end
        end else if (m_k == N) begin
            m_k <= -1;
        end else begin
            m_k <= m_k + 1;
            if (m_k + 1 == N) p_exp <= m_prod;
        end
    end

    // Cycle-by-cycle comparison against the model, away from the active edge.
    always @(negedge clk) begin
        if (rst === 1'b0) begin
            chk("cyc_busy", 32'(busy), 32'(m_k >= 0));
            chk("cyc_done", 32'(done), 32'(m_k == N));
            chk("cyc_p",    32'(p),    32'(p_exp));
        end
    end

    // Wait for done, counting negedges; the first negedge drops start and
    // scrambles the operands, which must not matter once accepted.
    task automatic wait_done(input bit drop_start, output int lat);
        lat = 0;
        do begin
            @(negedge clk);
            lat++;
            if (lat == 1 && drop_start) begin
                start = 1'b0;
                a = N'($urandom);
                b = N'($urandom);
            end
        end while (!done && lat < 4 * N);
        if (!done) begin
            vectors++;
            miscompares++;
            $display("FAIL wait_done: no done within %0d cycles", 4 * N);
        end
    endtask

    task automatic op(input string name, input logic [N-1:0] av, input logic [N-1:0] bv,
                      input logic [31:0] exp);
        int lat;
        start = 1'b1;
        a = av;
        b = bv;
        wait_done(1'b1, lat);
        chk({name, "_latency"}, 32'(lat), 32'(N + 1));
        chk({name, "_p"}, 32'(p), exp);
        @(negedge clk);
        chk({name, "_busy_fall"}, 32'(busy), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int lat;
        int cnt;
        rst   = 1'b1;
        start = 1'b0;
        a     = '0;
        b     = '0;
        repeat (2) @(negedge clk);
        chk("reset_busy", 32'(busy), 32'd0);
        chk("reset_done", 32'(done), 32'd0);
        chk("reset_p",    32'(p),    32'd0);
        rst = 1'b0;
        @(negedge clk);

        op("13x11", 8'd13, 8'd11, 32'd143);
        chk("model_pin_143", 32'(p_exp), 32'd143);
        op("255x255", 8'd255, 8'd255, 32'd65025);
        chk("model_pin_65025", 32'(p_exp), 32'd65025);
        op("0x200", 8'd0, 8'd200, 32'd0);
        op("200x0", 8'd200, 8'd0, 32'd0);

        // Requests during RUN and DONE are ignored.
        start = 1'b1; a = 8'd3; b = 8'd5;
        @(negedge clk);
        start = 1'b0;
        repeat (2) @(negedge clk);
        start = 1'b1; a = 8'd7; b = 8'd7;
        wait_done(1'b1, lat);
        chk("ignore_p", 32'(p), 32'd15);
        start = 1'b1; a = 8'd7; b = 8'd7;
        @(negedge clk);
        start = 1'b0;
        chk("ignore_idle", 32'(busy), 32'd0);
        cnt = 0;
        repeat (2 * N + 4) begin
            @(negedge clk);
            if (done) cnt++;
        end
        chk("ignore_no_second_done", 32'(cnt), 32'd0);
        chk("ignore_p_held", 32'(p), 32'd15);

        // Asynchronous reset in the middle of an operation.
        start = 1'b1; a = 8'd100; b = 8'd100;
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(negedge clk);
        @(posedge clk);
        #2 rst = 1'b1;
        #1;
        chk("abort_busy", 32'(busy), 32'd0);
        chk("abort_done", 32'(done), 32'd0);
        chk("abort_p",    32'(p),    32'd0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        op("6x9", 8'd6, 8'd9, 32'd54);

        // Start held high: back-to-back operations with one idle cycle.
        start = 1'b1; a = 8'd2; b = 8'd3;
        @(negedge clk);
        a = 8'd4; b = 8'd5;
        wait_done(1'b0, lat);
        chk("b2b_first_p", 32'(p), 32'd6);
        @(negedge clk);
        chk("b2b_idle_gap", 32'(busy), 32'd0);
        @(negedge clk);
        chk("b2b_restart", 32'(busy), 32'd1);
        wait_done(1'b0, lat);
        start = 1'b0;
        chk("b2b_spacing", 32'(lat + 2), 32'(N + 2));
        chk("b2b_second_p", 32'(p), 32'd20);
        repeat (3) @(negedge clk);
        chk("b2b_end_idle", 32'(busy), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
